// File: rtl/regfile_multiport.sv
// Multi-port integer register file with sized/sign-filled writes, prioritised
// same-cycle bypass to every read port, and a sequential clear sweep after reset.
module regfile_multiport #(
    parameter int REG_NUMBER        = 32,
    parameter int REG_ADDR_WIDTH    = $clog2(REG_NUMBER),
    parameter int REG_WIDTH_IN_BYTE = 4,
    parameter int REG_WIDTH_IN_BIT  = REG_WIDTH_IN_BYTE * 8,
    parameter int NUM_READ_PORTS    = 2,
    parameter int NUM_WRITE_PORTS   = 2,
    parameter int SIZE_WIDTH        = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0]    read_addr,
    output logic [NUM_READ_PORTS*REG_WIDTH_IN_BIT-1:0]  read_data,
    input  logic [NUM_WRITE_PORTS-1:0]                  write_enable,
    input  logic [NUM_WRITE_PORTS*REG_ADDR_WIDTH-1:0]   write_addr,
    input  logic [NUM_WRITE_PORTS*REG_WIDTH_IN_BIT-1:0] write_data,
    input  logic [NUM_WRITE_PORTS*SIZE_WIDTH-1:0]       write_size,
    input  logic [NUM_WRITE_PORTS-1:0]                  write_signed,
    output logic                                        ready
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam int LOG2_BYTES = $clog2(REG_WIDTH_IN_BYTE);
    localparam logic [REG_ADDR_WIDTH-1:0] LAST_IDX = REG_ADDR_WIDTH'(REG_NUMBER - 1);
    localparam logic [REG_ADDR_WIDTH-1:0] FIRST_IDX = REG_ADDR_WIDTH'(1);

    logic [0:0]                  state_q, state_d;
    logic [REG_ADDR_WIDTH-1:0]   clear_ptr_q, clear_ptr_d;
    logic [REG_WIDTH_IN_BIT-1:0] regfile_q [REG_NUMBER];

    logic [REG_WIDTH_IN_BIT-1:0] ext     [NUM_WRITE_PORTS];
    logic [REG_ADDR_WIDTH-1:0]   wr_addr [NUM_WRITE_PORTS];

    // Keep the low n bytes of the raw data and fill the rest with zero or the
    // top kept bit; size codes at or beyond full width pass data unchanged.
    function automatic logic [REG_WIDTH_IN_BIT-1:0] extend_data(
        input logic [REG_WIDTH_IN_BIT-1:0] data,
        input logic [SIZE_WIDTH-1:0]       size,
        input logic                        sgn
    );
        logic [REG_WIDTH_IN_BIT-1:0] res;
        logic                        fill;
        int                          nbits;
        int                          size_int;
        size_int = int'(size);
        if (size_int >= LOG2_BYTES) begin
            nbits = REG_WIDTH_IN_BIT;
        end else begin
            nbits = 8 << size_int;
        end
        fill = sgn & data[nbits-1];
        for (int b = 0; b < REG_WIDTH_IN_BIT; b++) begin
            res[b] = (b < nbits) ? data[b] : fill;
        end
        return res;
    endfunction

    always_comb begin
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            wr_addr[w] = write_addr[w*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            ext[w]     = extend_data(write_data[w*REG_WIDTH_IN_BIT +: REG_WIDTH_IN_BIT],
                                     write_size[w*SIZE_WIDTH +: SIZE_WIDTH],
                                     write_signed[w]);
        end
    end

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        if (state_q == ST_CLEAR) begin
            clear_ptr_d = clear_ptr_q + FIRST_IDX;
            if (clear_ptr_q == LAST_IDX) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            clear_ptr_q <= FIRST_IDX;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
        end
    end

    // Array has no reset so it can map onto RAM; later ports override earlier
    // ones on an address collision, giving the higher index priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                regfile_q[clear_ptr_q] <= '0;
            end else begin
                for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                    if (write_enable[w] && (wr_addr[w] != '0)) begin
                        regfile_q[wr_addr[w]] <= ext[w];
                    end
                end
            end
        end
    end

    always_comb begin
        read_data = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            logic [REG_ADDR_WIDTH-1:0]   ra;
            logic [REG_WIDTH_IN_BIT-1:0] rd;
            ra = read_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            rd = '0;
            if ((state_q == ST_RUN) && (ra != '0)) begin
                rd = regfile_q[ra];
                for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                    if (write_enable[w] && (wr_addr[w] == ra)) begin
                        rd = ext[w];
                    end
                end
            end
            read_data[p*REG_WIDTH_IN_BIT +: REG_WIDTH_IN_BIT] = rd;
        end
    end

    assign ready = (state_q == ST_RUN);

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: clear sweep, sized writes, bypass,
// collisions, x0 handling and mid-sweep reset.
module tb_regfile_multiport;

    logic        clk;
    logic        reset;
    logic [9:0]  read_addr;
    logic [63:0] read_data;
    logic [1:0]  write_enable;
    logic [9:0]  write_addr;
    logic [63:0] write_data;
    logic [3:0]  write_size;
    logic [1:0]  write_signed;
    logic        ready;

    int n_cmp;
    int n_err;

    regfile_multiport dut (
        .clk          (clk),
        .reset        (reset),
        .read_addr    (read_addr),
        .read_data    (read_data),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_size   (write_size),
        .write_signed (write_signed),
        .ready        (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [1:0]  ws0, ws1;
        logic        sg0, sg1;
        logic [4:0]  ra0, ra1;
        logic [31:0] exp0, exp1;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        write_enable = 2'b00;
        write_addr   = '0;
        write_data   = '0;
        write_size   = '0;
        write_signed = '0;
        read_addr    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after reset release until ready, checking zero reads on the way.
    task automatic run_sweep(input string tag, input bit drop_write);
        int edges;
        edges = 0;
        for (int k = 1; k <= 40; k++) begin
            read_addr = {5'd31, 5'(k % 32)};
            if (drop_write && k == 10) begin
                write_enable = 2'b01;
                write_addr   = {5'd0, 5'd5};
                write_data   = {32'h0, 32'h0000_1234};
                write_size   = 4'b0010;
            end else begin
                write_enable = 2'b00;
            end
            #1;
            if (k == 1 || k == 10 || k == 30) begin
                check({tag, "_rd0_clear"}, read_data[31:0], 32'h0);
                check({tag, "_rd1_clear"}, read_data[63:32], 32'h0);
            end
            tick();
            edges = k;
            if (ready) break;
        end
        write_enable = 2'b00;
        check({tag, "_sweep_len"}, 32'(edges), 32'd31);
        check({tag, "_ready"}, {31'h0, ready}, 32'h1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_inputs();

        vecs[0]  = '{"x5_dropped", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd5, 5'd5, 32'h0, 32'h0};
        vecs[1]  = '{"byte_sgn_byp", 2'b01, 5'd3, 5'd0, 32'hDEADBE80, 32'h0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd3, 5'd3, 32'hFFFFFF80, 32'hFFFFFF80};
        vecs[2]  = '{"byte_sgn_reg", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd3, 5'd0, 32'hFFFFFF80, 32'h0};
        vecs[3]  = '{"byte_zero_byp", 2'b01, 5'd3, 5'd0, 32'hDEADBE80, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd3, 5'd3, 32'h00000080, 32'h00000080};
        vecs[4]  = '{"byte_zero_reg", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd3, 32'h0, 32'h00000080};
        vecs[5]  = '{"half_sgn_byp", 2'b01, 5'd3, 5'd0, 32'h0000F00D, 32'h0, 2'd1, 2'd0, 1'b1, 1'b0, 5'd3, 5'd3, 32'hFFFFF00D, 32'hFFFFF00D};
        vecs[6]  = '{"half_sgn_reg", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd3, 5'd3, 32'hFFFFF00D, 32'hFFFFF00D};
        vecs[7]  = '{"half_zero_p1", 2'b10, 5'd0, 5'd4, 32'h0, 32'hFFFFF00D, 2'd0, 2'd1, 1'b0, 1'b0, 5'd4, 5'd3, 32'h0000F00D, 32'hFFFFF00D};
        vecs[8]  = '{"size3_byp", 2'b01, 5'd3, 5'd0, 32'hDEADBE80, 32'h0, 2'd3, 2'd0, 1'b1, 1'b0, 5'd3, 5'd4, 32'hDEADBE80, 32'h0000F00D};
        vecs[9]  = '{"size3_reg", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd3, 5'd3, 32'hDEADBE80, 32'hDEADBE80};
        vecs[10] = '{"x7_bypass", 2'b10, 5'd0, 5'd7, 32'h0, 32'hCAFEF00D, 2'd0, 2'd2, 1'b0, 1'b0, 5'd7, 5'd7, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[11] = '{"x7_hold", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd7, 5'd7, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[12] = '{"x9_collide", 2'b11, 5'd9, 5'd9, 32'h11111111, 32'h22222222, 2'd2, 2'd2, 1'b0, 1'b0, 5'd9, 5'd9, 32'h22222222, 32'h22222222};
        vecs[13] = '{"x9_hold", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd9, 5'd7, 32'h22222222, 32'hCAFEF00D};
        vecs[14] = '{"x0_write", 2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd2, 2'd2, 1'b1, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0};
        vecs[15] = '{"x0_after", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0};

        reset = 1'b1;
        tick();
        tick();
        tick();
        check("ready_in_reset", {31'h0, ready}, 32'h0);
        read_addr = {5'd31, 5'd1};
        #1;
        check("rd0_in_reset", read_data[31:0], 32'h0);
        reset = 1'b0;
        run_sweep("init", 1'b1);

        for (int i = 0; i < 16; i++) begin
            write_enable = vecs[i].we;
            write_addr   = {vecs[i].wa1, vecs[i].wa0};
            write_data   = {vecs[i].wd1, vecs[i].wd0};
            write_size   = {vecs[i].ws1, vecs[i].ws0};
            write_signed = {vecs[i].sg1, vecs[i].sg0};
            read_addr    = {vecs[i].ra1, vecs[i].ra0};
            #1;
            check({vecs[i].name, "_rd0"}, read_data[31:0], vecs[i].exp0);
            check({vecs[i].name, "_rd1"}, read_data[63:32], vecs[i].exp1);
            tick();
        end
        idle_inputs();

        // Mid-sweep reset: pulse on edge 20, then a full sweep must follow.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k < 20; k++) tick();
        check("mid_ready_e19", {31'h0, ready}, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_ready_e20", {31'h0, ready}, 32'h0);
        run_sweep("restart", 1'b0);

        read_addr = {5'd7, 5'd9};
        #1;
        check("x9_cleared", read_data[31:0], 32'h0);
        check("x7_cleared", read_data[63:32], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Next-generation integer register file: parametrised read-port and write-port counts.
- Write sizes of 1/2/4/... bytes with zero- or sign-fill.
- Prioritised multi-write bypass to every read port.
- Sequential clear sweep after reset, so the array can map onto RAM-style storage without a parallel reset.
- Sits in the decode/writeback stages of the core; x0 is hardwired to zero.

Parameters:
- REG_NUMBER, 32, number of architectural registers (power of 2, >=2).
- REG_ADDR_WIDTH, $clog2(REG_NUMBER), register address width.
- REG_WIDTH_IN_BYTE, 4, register width in bytes (power of 2).
- REG_WIDTH_IN_BIT, REG_WIDTH_IN_BYTE*8, register width in bits.
- NUM_READ_PORTS, 2, number of combinational read ports (>=1).
- NUM_WRITE_PORTS, 2, number of write ports (>=1); higher index has higher priority.
- SIZE_WIDTH, 2, width of each write-size code.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- read_addr  input  NUM_READ_PORTS*REG_ADDR_WIDTH  packed read addresses; port p at bits [p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH].
- read_data  output  NUM_READ_PORTS*REG_WIDTH_IN_BIT  packed read data, same packing as read_addr.
- write_enable  input  NUM_WRITE_PORTS  per-port write strobe.
- write_addr  input  NUM_WRITE_PORTS*REG_ADDR_WIDTH  packed write addresses.
- write_data  input  NUM_WRITE_PORTS*REG_WIDTH_IN_BIT  packed raw write data.
- write_size  input  NUM_WRITE_PORTS*SIZE_WIDTH  per-port size code s; written width = min(2^s, REG_WIDTH_IN_BYTE) bytes.
- write_signed  input  NUM_WRITE_PORTS  per-port fill select: 1 = sign-fill, 0 = zero-fill.
- ready  output  1  high when the clear sweep is done and the file accepts writes.

Behaviour:
- FSM states: CLEAR, RUN.
  - reset=1 at an edge: state<=CLEAR, clear_ptr<=1. No array write happens while reset is held.
- CLEAR, reset=0: each edge writes regfile[clear_ptr]<=0 and increments clear_ptr.
  - The edge that clears index REG_NUMBER-1 sets state<=RUN.
  - The sweep takes exactly REG_NUMBER-1 edges after reset deasserts. ready rises after the last clear edge (31 edges for defaults).
- ready = (state==RUN). ready is 0 in reset and during CLEAR.
- In CLEAR:
  - All write_enable inputs are ignored; no write reaches the array.
  - All read_data ports return 0.
  - No bypass.
- reset asserted mid-sweep or in RUN returns to CLEAR with clear_ptr=1; the sweep restarts from scratch.
- Write extension, per port, combinational:
  - n = min(2^write_size, REG_WIDTH_IN_BYTE) bytes.
  - ext = write_data[8n-1:0], upper bits filled with 0, or with bit 8n-1 when write_signed=1.
  - Size codes at or above full width write the full register unchanged.
- RUN writes: on each edge, for each port w with write_enable[w]=1 and write_addr[w]!=0, regfile[write_addr[w]]<=ext[w].
  - If several ports target the same address, the highest-index port wins.
  - Writes to x0 are discarded.
  - One-cycle write latency.
- Reads, combinational, per read port p, in RUN:
  - read_addr[p]==0 -> 0.
  - Else, if any enabled write port targets read_addr[p] -> ext of the highest-index such port (same-cycle bypass).
  - Else -> regfile[read_addr[p]].
- Bypass is independent per read port; any number of read ports may bypass at once.
- x0 always reads 0, regardless of bypass, size or sign.

Test Plan:
- Clear sweep: reset 3 cycles, then release. ready=0 for exactly 31 edges, then 1. Reads of x1..x31 return 0 throughout. A write of 0x1234 to x5 on edge 10 of the sweep is dropped; x5 reads 0 after ready.
- Size/fill: in RUN, port0 writes x3 with data 0xDEADBE80, size 0 (byte), signed=1 -> x3 reads 0xFFFFFF80. Same write with signed=0 -> 0x00000080. Half-word 0x0000F00D, signed=1 -> 0xFFFFF00D. Size 3 -> 0xDEADBE80.
- Bypass: port1 writes x7=0xCAFEF00D (word) while both read ports address x7 in the same cycle -> both read 0xCAFEF00D combinationally. Next cycle, with no write, both still read 0xCAFEF00D.
- Write collision: port0 writes x9=0x11111111 and port1 writes x9=0x22222222 in the same cycle. Bypass read shows 0x22222222, and x9 holds 0x22222222 afterwards.
- x0: both ports write x0=0xFFFFFFFF with read_addr=0 -> read_data 0 in that cycle and the next.
- Mid-sweep reset: reset pulsed 1 cycle at sweep edge 20 -> ready stays 0, and a full 31-edge sweep restarts from the edge after reset drops.
